instr_fetch_unit: RTL and testbench

- Instruction fetch front end for the single-cycle RISC-V core.
- Holds the PC and issues one-outstanding-request reads to instruction memory through a req/gnt/rvalid handshake.
- Presents each fetched instruction and its PC to the decode stage with a valid/ready handshake.
- Consumes the branch/jump redirect produced by the decode/branch logic (PCSrc plus target), flushing or draining any in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-outstanding imem reads and
// hands instructions to decode over valid/ready, with branch/jump redirect.
module instr_fetch_unit #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_count
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

  localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target;

  assign target    = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= Nop;
      id_pc       <= '0;
      fetch_count <= '0;
    end else begin
      // Redirect wins everywhere except IDLE; any pending HOLD instruction is dropped.
      if (redirect && (state_q != StIdle)) begin
        pc_q     <= target;
        id_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (redirect) begin
            state_q <= imem_gnt ? StDrain : StReq;
          end else if (imem_gnt) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redirect) begin
            state_q <= imem_rvalid ? StReq : StDrain;
          end else if (imem_rvalid) begin
            id_instr <= imem_rdata;
            id_pc    <= pc_q;
            id_valid <= 1'b1;
            pc_q     <= pc_q + XLEN'(4);
            state_q  <= StHold;
          end
        end
        StHold: begin
          // A transfer coinciding with a redirect still counts.
          if (id_ready) begin
            fetch_count <= fetch_count + 32'd1;
          end
          if (redirect || id_ready) begin
            id_valid <= 1'b0;
            state_q  <= StReq;
          end
        end
        StDrain: begin
          if (imem_rvalid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle table, async reset sequence, and a randomized
// run against a transaction-level model of the PC/instruction stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic        gnt, rv, rdy, redir;
    logic [31:0] rdata, rpc;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_instr, e_cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic g, rv, input logic [31:0] rd, input logic rdy, rdr,
                              input logic [31:0] rpc, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, ei, ec);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rdr; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_pc, exp_cnt, out_addr, prev_pc, prev_instr;
    logic        outstanding, prev_hold, granted;
    int          dly, stall;

    // Row: inputs for this cycle | outputs observed during this cycle.
    tbl[0]  = mk(1, 0, 0, 1, 0, 0,           0, 32'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0,           1, 32'h00, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 32'h0050_0093, 1, 0, 0, 0, 32'h00, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0,           0, 32'h04, 1, 32'h00, 32'h0050_0093, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0,           1, 32'h04, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0,           1, 32'h04, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0,           1, 32'h04, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 1, 0, 0,           1, 32'h04, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,           0, 32'h04, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 32'h0000_0AAA, 0, 0, 0, 0, 32'h04, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,           0, 32'h08, 1, 32'h04, 32'h0000_0AAA, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 32'h50,      0, 32'h08, 1, 32'h04, 32'h0000_0AAA, 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 0,           1, 32'h50, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 32'h103,     0, 32'h50, 0, 0, 0, 1);
    tbl[14] = mk(0, 1, 32'h0000_0DDD, 1, 0, 0, 0, 32'h100, 0, 0, 0, 1);
    tbl[15] = mk(1, 0, 0, 1, 0, 0,           1, 32'h100, 0, 0, 0, 1);
    tbl[16] = mk(0, 1, 32'h0000_0BBB, 1, 1, 32'h42, 0, 32'h100, 0, 0, 0, 1);
    tbl[17] = mk(1, 0, 0, 1, 0, 0,           1, 32'h40, 0, 0, 0, 1);
    tbl[18] = mk(0, 1, 32'h0000_0CCC, 1, 0, 0, 0, 32'h40, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 1, 1, 32'h80,      0, 32'h44, 1, 32'h40, 32'h0000_0CCC, 1);
    tbl[20] = mk(0, 0, 0, 1, 0, 0,           1, 32'h80, 0, 0, 0, 2);

    rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    id_ready = 0; redirect = 0; redirect_pc = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, id_valid}, 0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_pc", id_pc, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_req", {31'b0, imem_req}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      id_ready = tbl[i].rdy; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("t%0d_count", i), fetch_count, tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_idpc", i), id_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_instr", i), id_instr, tbl[i].e_instr);
      end
      @(negedge clk);
    end

    // Async reset in the middle of WAIT.
    imem_gnt = 1; imem_rvalid = 0; redirect = 0;
    @(negedge clk);
    imem_gnt = 0;
    chk("mid_wait_req", {31'b0, imem_req}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 0);
    chk("arst_count", fetch_count, 0);
    chk("arst_instr", id_instr, 32'h0000_0013);
    chk("arst_valid", {31'b0, id_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the stream model.
    exp_pc = 0; exp_cnt = 0; outstanding = 0; dly = 0; stall = 0;
    prev_hold = 0; prev_pc = 0; prev_instr = 0; out_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("r_count", fetch_count, exp_cnt);
      chk("r_req_in_hold", {31'b0, imem_req & id_valid}, 0);
      if (imem_req) chk("r_req_addr", imem_addr, exp_pc);
      if (prev_hold) begin
        chk("r_hold_valid", {31'b0, id_valid}, 1);
        chk("r_hold_pc", id_pc, prev_pc);
        chk("r_hold_instr", id_instr, prev_instr);
      end

      imem_gnt    = ($urandom_range(0, 3) != 0);
      imem_rvalid = outstanding && (dly == 0);
      imem_rdata  = imem_rvalid ? mem_word(out_addr) : $urandom;
      if (stall > 0) begin
        id_ready = 0; stall--;
      end else if ($urandom_range(0, 15) == 0) begin
        id_ready = 0; stall = 5;
      end else begin
        id_ready = $urandom_range(0, 1) != 0;
      end
      redirect    = (cyc > 1) && ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom & 32'h0000_0FFF;
      #1;

      if (id_valid && id_ready) begin
        chk("r_xfer_pc", id_pc, exp_pc);
        chk("r_xfer_instr", id_instr, mem_word(exp_pc));
        exp_pc  = exp_pc + 4;
        exp_cnt = exp_cnt + 1;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      prev_hold  = id_valid && !id_ready && !redirect;
      prev_pc    = id_pc;
      prev_instr = id_instr;

      granted = imem_req && imem_gnt;
      if (granted) chk("r_one_outstanding", {31'b0, outstanding && !imem_rvalid}, 0);
      if (imem_rvalid) outstanding = 0;
      else if (outstanding) dly--;
      if (granted) begin
        outstanding = 1; out_addr = imem_addr; dly = $urandom_range(0, 2);
      end
      @(negedge clk);
    end
    chk("r_progress", {31'b0, exp_cnt > 100}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
